// File: rtl/btb_update_sched.sv
// BTB update scheduler: buffers committed branch/jump updates in a small
// coalescing queue, drains one per cycle into the BTB, and runs a full invalidation sweep.
module btb_update_sched #(
   parameter int unsigned COMMIT_WIDTH = 2,
   parameter int unsigned QDEPTH       = 4,
   parameter int unsigned BTB_DEPTH    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [COMMIT_WIDTH-1:0]              cm_valid,
   input  logic [COMMIT_WIDTH-1:0][31:0]        cm_pc,
   input  logic [COMMIT_WIDTH-1:0][31:0]        cm_target,
   input  logic [COMMIT_WIDTH-1:0]              cm_is_jump,
   output logic                                 upd_en,
   output logic [31:0]                          upd_pc,
   output logic [31:0]                          upd_target,
   output logic                                 upd_is_jump,
   input  logic                                 upd_ready,
   input  logic                                 flush_req,
   output logic                                 inv_en,
   output logic [$clog2(BTB_DEPTH)-1:0]         inv_idx,
   output logic                                 busy,
   output logic [15:0]                          drop_cnt
);

   localparam int unsigned PTR_W  = $clog2(QDEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned IDX_W  = $clog2(BTB_DEPTH);
   localparam int unsigned LANE_W = $clog2(COMMIT_WIDTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        is_jump;
   } upd_entry_t;

   typedef enum logic {S_IDLE, S_FLUSH} state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   upd_entry_t          ent_q [QDEPTH];
   upd_entry_t          ent_d [QDEPTH];
   logic [QDEPTH-1:0]   vld_q, vld_d;
   logic [PTR_W-1:0]    head_q, head_d;
   logic [PTR_W-1:0]    tail_q, tail_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [15:0]         drop_q, drop_d;

   logic                deq;
   logic [CNT_W-1:0]    free;
   logic [LANE_W-1:0]   ndrop;
   logic                hit;
   logic [PTR_W-1:0]    hit_idx;
   logic [16:0]         drop_sum;

   // State and queue registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ent_q   <= '{default: '0};
         vld_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ent_q   <= ent_d;
         vld_q   <= vld_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   // Next state and sweep index; a flush request always restarts at entry 0
   always_comb begin
      state_d = state_q;
      idx_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (flush_req) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (flush_req) begin
               idx_d = '0;
            end else if (idx_q == IDX_W'(BTB_DEPTH - 1)) begin
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      upd_en      = (cnt_q != '0) && (state_q == S_IDLE);
      upd_pc      = ent_q[head_q].pc;
      upd_target  = ent_q[head_q].target;
      upd_is_jump = ent_q[head_q].is_jump;
      inv_en      = (state_q == S_FLUSH);
      busy        = (state_q == S_FLUSH);
      inv_idx     = idx_q;
      drop_cnt    = drop_q;
   end

   // Queue update: dequeue first so the departing head cannot absorb a lane,
   // then lanes in order coalesce into live entries or take a free slot.
   always_comb begin
      ent_d    = ent_q;
      vld_d    = vld_q;
      head_d   = head_q;
      tail_d   = tail_q;
      cnt_d    = cnt_q;
      drop_d   = drop_q;
      deq      = upd_en && upd_ready && !flush_req;
      free     = CNT_W'(QDEPTH) - cnt_q + CNT_W'(deq);
      ndrop    = '0;
      hit      = 1'b0;
      hit_idx  = '0;
      drop_sum = '0;
      if (flush_req) begin
         vld_d  = '0;
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else if (state_q == S_IDLE) begin
         if (deq) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
            cnt_d         = cnt_q - CNT_W'(1);
         end
         for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            if (cm_valid[k]) begin
               hit     = 1'b0;
               hit_idx = '0;
               for (int unsigned j = 0; j < QDEPTH; j++) begin
                  if (vld_d[j] && (ent_d[j].pc == cm_pc[k]) &&
                      (ent_d[j].is_jump == cm_is_jump[k])) begin
                     hit     = 1'b1;
                     hit_idx = PTR_W'(j);
                  end
               end
               if (hit) begin
                  ent_d[hit_idx].target = cm_target[k];
               end else if (free != '0) begin
                  ent_d[tail_d] = '{pc: cm_pc[k], target: cm_target[k], is_jump: cm_is_jump[k]};
                  vld_d[tail_d] = 1'b1;
                  tail_d        = tail_d + PTR_W'(1);
                  cnt_d         = cnt_d + CNT_W'(1);
                  free          = free - CNT_W'(1);
               end else begin
                  ndrop = ndrop + LANE_W'(1);
               end
            end
         end
         drop_sum = 17'(drop_q) + 17'(ndrop);
         drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

endmodule

// File: tb/tb_btb_update_sched.sv
// Directed bench for btb_update_sched: queue ordering, coalescing, overflow,
// flush sweep, re-flush and mid-sweep reset.
module tb_btb_update_sched;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        cm_valid;
   logic [1:0][31:0]  cm_pc;
   logic [1:0][31:0]  cm_target;
   logic [1:0]        cm_is_jump;
   logic              upd_en;
   logic [31:0]       upd_pc;
   logic [31:0]       upd_target;
   logic              upd_is_jump;
   logic              upd_ready;
   logic              flush_req;
   logic              inv_en;
   logic [3:0]        inv_idx;
   logic              busy;
   logic [15:0]       drop_cnt;

   int errors = 0;
   int checks = 0;

   btb_update_sched #(.COMMIT_WIDTH(2), .QDEPTH(4), .BTB_DEPTH(16)) dut (
      .clk(clk), .rst(rst),
      .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_target(cm_target), .cm_is_jump(cm_is_jump),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target), .upd_is_jump(upd_is_jump),
      .upd_ready(upd_ready), .flush_req(flush_req),
      .inv_en(inv_en), .inv_idx(inv_idx), .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lane(input int k, input logic [31:0] pc, input logic [31:0] tgt, input logic j);
      cm_valid[k]   = 1'b1;
      cm_pc[k]      = pc;
      cm_target[k]  = tgt;
      cm_is_jump[k] = j;
   endtask

   task automatic clr_lanes();
      cm_valid   = '0;
      cm_pc      = '0;
      cm_target  = '0;
      cm_is_jump = '0;
   endtask

   task automatic expect_upd(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic j);
      check({tag, "_en"}, 32'(upd_en), 32'd1);
      check({tag, "_pc"}, upd_pc, pc);
      check({tag, "_tgt"}, upd_target, tgt);
      check({tag, "_jmp"}, 32'(upd_is_jump), 32'(j));
   endtask

   initial begin
      rst       = 1'b1;
      upd_ready = 1'b0;
      flush_req = 1'b0;
      clr_lanes();
      tick();
      tick();
      check("rst_upd_en", 32'(upd_en), 32'd0);
      check("rst_upd_pc", upd_pc, 32'd0);
      check("rst_upd_tgt", upd_target, 32'd0);
      check("rst_upd_jmp", 32'(upd_is_jump), 32'd0);
      check("rst_inv_en", 32'(inv_en), 32'd0);
      check("rst_inv_idx", 32'(inv_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // Single update, one cycle latency, then gone
      upd_ready = 1'b1;
      lane(0, 32'h1000, 32'h2000, 1'b0);
      check("single_pre_en", 32'(upd_en), 32'd0);
      tick();
      clr_lanes();
      expect_upd("single", 32'h1000, 32'h2000, 1'b0);
      tick();
      check("single_post_en", 32'(upd_en), 32'd0);

      // Coalesce across cycles: one update with the later target
      upd_ready = 1'b0;
      lane(0, 32'h1000, 32'h2000, 1'b0);
      tick();
      lane(0, 32'h1000, 32'h3000, 1'b0);
      tick();
      clr_lanes();
      expect_upd("coal", 32'h1000, 32'h3000, 1'b0);
      upd_ready = 1'b1;
      tick();
      check("coal_once", 32'(upd_en), 32'd0);

      // Same pc in both lanes merges, higher lane wins; jump with same pc is distinct
      upd_ready = 1'b0;
      lane(0, 32'h300, 32'hA, 1'b0);
      lane(1, 32'h300, 32'hB, 1'b0);
      tick();
      clr_lanes();
      lane(0, 32'h300, 32'hC, 1'b1);
      tick();
      clr_lanes();
      upd_ready = 1'b1;
      expect_upd("dup0", 32'h300, 32'hB, 1'b0);
      tick();
      expect_upd("dup1", 32'h300, 32'hC, 1'b1);
      tick();
      check("dup_end", 32'(upd_en), 32'd0);

      // Departing head does not absorb a matching lane
      upd_ready = 1'b0;
      lane(0, 32'h400, 32'h1, 1'b0);
      tick();
      upd_ready = 1'b1;
      lane(0, 32'h400, 32'h2, 1'b0);
      tick();
      clr_lanes();
      expect_upd("hdx", 32'h400, 32'h2, 1'b0);
      tick();
      check("hdx_end", 32'(upd_en), 32'd0);

      // Overflow: 6 lanes into 4 slots, 2 drops, drain in lane order
      upd_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         lane(0, 32'h100 + 32'(8 * c), 32'h1100 + 32'(8 * c), 1'b0);
         lane(1, 32'h104 + 32'(8 * c), 32'h1104 + 32'(8 * c), 1'b0);
         tick();
      end
      clr_lanes();
      check("ovf_drop", 32'(drop_cnt), 32'd2);
      upd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_upd($sformatf("ovf%0d", i), 32'h100 + 32'(4 * i), 32'h1100 + 32'(4 * i), 1'b0);
         tick();
      end
      check("ovf_end", 32'(upd_en), 32'd0);

      // Full queue with simultaneous dequeue accepts one new lane
      upd_ready = 1'b0;
      lane(0, 32'h200, 32'h2200, 1'b0);
      lane(1, 32'h204, 32'h2204, 1'b0);
      tick();
      lane(0, 32'h208, 32'h2208, 1'b0);
      lane(1, 32'h20c, 32'h220c, 1'b0);
      tick();
      clr_lanes();
      upd_ready = 1'b1;
      lane(0, 32'h210, 32'h2210, 1'b0);
      expect_upd("full_h", 32'h200, 32'h2200, 1'b0);
      tick();
      clr_lanes();
      check("full_drop", 32'(drop_cnt), 32'd2);
      for (int i = 0; i < 4; i++) begin
         expect_upd($sformatf("full%0d", i), 32'h204 + 32'(4 * i), 32'h2204 + 32'(4 * i), 1'b0);
         tick();
      end
      check("full_end", 32'(upd_en), 32'd0);

      // Flush with 3 queued; lanes during the sweep are discarded, not dropped
      upd_ready = 1'b0;
      lane(0, 32'h500, 32'h1, 1'b0);
      lane(1, 32'h504, 32'h2, 1'b0);
      tick();
      clr_lanes();
      lane(0, 32'h508, 32'h3, 1'b0);
      tick();
      clr_lanes();
      check("fl_pre_en", 32'(upd_en), 32'd1);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      lane(0, 32'h600, 32'h6, 1'b0);
      lane(1, 32'h604, 32'h7, 1'b1);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("fl_idx%0d", i), 32'(inv_idx), 32'(i));
         check($sformatf("fl_inv%0d", i), 32'(inv_en), 32'd1);
         check($sformatf("fl_busy%0d", i), 32'(busy), 32'd1);
         check($sformatf("fl_upd%0d", i), 32'(upd_en), 32'd0);
         tick();
      end
      clr_lanes();
      check("fl_end_busy", 32'(busy), 32'd0);
      check("fl_end_inv", 32'(inv_en), 32'd0);
      check("fl_end_upd", 32'(upd_en), 32'd0);
      check("fl_end_drop", 32'(drop_cnt), 32'd2);
      tick();
      check("fl_end_upd2", 32'(upd_en), 32'd0);

      // Re-flush at index 7 restarts the full 16-cycle sweep
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("rf_idx7", 32'(inv_idx), 32'd7);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("rf_idx%0d", i), 32'(inv_idx), 32'(i));
         check($sformatf("rf_busy%0d", i), 32'(busy), 32'd1);
         tick();
      end
      check("rf_end_busy", 32'(busy), 32'd0);

      // Reset mid-sweep with a non-zero drop count
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("mr_idx3", 32'(inv_idx), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_inv", 32'(inv_en), 32'd0);
      check("mr_idx", 32'(inv_idx), 32'd0);
      check("mr_drop", 32'(drop_cnt), 32'd0);
      check("mr_upd", 32'(upd_en), 32'd0);
      tick();
      check("mr_busy2", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
